// File: rtl/dct8_pkg.sv
// Shared constants for the 8-point DCT front end: block length, sequencer
// state encoding and the default sample widths used by dct8_stage1.
package dct8_pkg;

    localparam int N              = 8;
    localparam int CNT_W          = $clog2(N);
    localparam int DCT_DATA_IN_W  = 12;
    localparam int DCT_DATA_OUT_W = 16;

    typedef logic [1:0] seq_state_t;

    localparam seq_state_t ST_FLUSH = 2'd0;
    localparam seq_state_t ST_FEED  = 2'd1;
    localparam seq_state_t ST_DRAIN = 2'd2;

    function automatic logic is_last(input logic [CNT_W-1:0] cnt);
        return cnt == CNT_W'(N - 1);
    endfunction

endpackage

// File: rtl/dct8_block_sequencer.sv
// Block-level controller for dct8_stage1: admits exactly N samples per block,
// waits for the N butterfly outputs, frames them, and owns the datapath reset.
module dct8_block_sequencer
    import dct8_pkg::*;
#(
    parameter int DATA_IN_WIDTH  = DCT_DATA_IN_W,
    parameter int DATA_OUT_WIDTH = DCT_DATA_OUT_W,
    parameter int TIMEOUT_CYCLES = 32,
    parameter int FLUSH_CYCLES   = 2,
    parameter int BLK_IDX_WIDTH  = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic signed [DATA_IN_WIDTH-1:0]  s_data,
    output logic                             dp_in_valid,
    output logic signed [DATA_IN_WIDTH-1:0]  dp_in_sample,
    output logic                             dp_rst_n,
    input  logic                             dp_out_valid,
    input  logic signed [DATA_OUT_WIDTH-1:0] dp_out_sample,
    output logic                             m_valid,
    output logic signed [DATA_OUT_WIDTH-1:0] m_data,
    output logic                             m_first,
    output logic                             m_last,
    output logic [BLK_IDX_WIDTH-1:0]         m_block_idx,
    input  logic                             flush,
    input  logic                             err_clear,
    output logic                             busy,
    output logic                             err_timeout,
    output logic                             err_unexpected
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FL_W = $clog2(FLUSH_CYCLES + 1);

    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLUSH_CYCLES - 1);

    seq_state_t r_state;
    seq_state_t w_next_state;

    logic [FL_W-1:0]                  r_flush_cnt;
    logic [CNT_W-1:0]                 r_feed_cnt;
    logic [CNT_W-1:0]                 r_out_cnt;
    logic [WD_W-1:0]                  r_wd_cnt;
    logic [BLK_IDX_WIDTH-1:0]         r_block_cnt;
    logic                             r_dp_rst_n;

    logic                             r_m_valid;
    logic                             r_m_first;
    logic                             r_m_last;
    logic signed [DATA_OUT_WIDTH-1:0] r_m_data;
    logic [BLK_IDX_WIDTH-1:0]         r_m_block_idx;

    logic                             r_err_timeout;
    logic                             r_err_unexpected;

    logic                             w_s_ready;
    logic                             w_dp_in_valid;
    logic signed [DATA_IN_WIDTH-1:0]  w_dp_in_sample;
    logic                             w_busy;

    logic                             w_flush_done;
    logic                             w_feed_done;
    logic                             w_beat;
    logic                             w_drain_done;
    logic                             w_wd_expire;
    logic                             w_unexpected;

    // A beat is only accepted in DRAIN and never in a cycle that is flushing.
    assign w_flush_done = (r_state == ST_FLUSH) && !flush && (r_flush_cnt == FL_LAST);
    assign w_feed_done  = (r_state == ST_FEED) && w_dp_in_valid && is_last(r_feed_cnt);
    assign w_beat       = (r_state == ST_DRAIN) && dp_out_valid && !flush;
    assign w_drain_done = w_beat && is_last(r_out_cnt);
    assign w_wd_expire  = (r_state == ST_DRAIN) && !flush && !w_drain_done
                          && (r_wd_cnt == WD_LAST);
    assign w_unexpected = dp_out_valid && (r_state != ST_DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            r_state <= ST_FLUSH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin : next_state_logic
        w_next_state = r_state;
        if (flush) begin
            w_next_state = ST_FLUSH;
        end else begin
            case (r_state)
                ST_FLUSH: if (w_flush_done) w_next_state = ST_FEED;
                ST_FEED:  if (w_feed_done)  w_next_state = ST_DRAIN;
                ST_DRAIN: begin
                    if (w_drain_done) begin
                        w_next_state = ST_FEED;
                    end else if (w_wd_expire) begin
                        w_next_state = ST_FLUSH;
                    end
                end
                default:  w_next_state = ST_FLUSH;
            endcase
        end
    end

    always_comb begin : output_decode
        w_s_ready      = 1'b0;
        w_dp_in_valid  = 1'b0;
        w_dp_in_sample = '0;
        w_busy         = 1'b1;
        if (r_state == ST_FEED) begin
            w_s_ready      = !flush;
            w_dp_in_valid  = s_valid && !flush;
            w_dp_in_sample = s_data;
            w_busy         = (r_feed_cnt != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : counters
        if (!rst_n) begin
            r_flush_cnt <= '0;
            r_feed_cnt  <= '0;
            r_out_cnt   <= '0;
            r_wd_cnt    <= '0;
            r_block_cnt <= '0;
            r_dp_rst_n  <= 1'b0;
        end else begin
            // Flush held high keeps restarting the hold-off window.
            if ((r_state == ST_FLUSH) && (w_next_state == ST_FLUSH) && !flush) begin
                r_flush_cnt <= r_flush_cnt + FL_W'(1);
            end else begin
                r_flush_cnt <= '0;
            end

            r_dp_rst_n <= (w_next_state != ST_FLUSH);

            if (w_next_state == ST_FLUSH) begin
                r_feed_cnt <= '0;
            end else if (w_dp_in_valid) begin
                r_feed_cnt <= r_feed_cnt + CNT_W'(1);
            end

            if (w_next_state != ST_DRAIN) begin
                r_out_cnt <= '0;
            end else if (w_beat) begin
                r_out_cnt <= r_out_cnt + CNT_W'(1);
            end

            if ((r_state == ST_DRAIN) && (w_next_state == ST_DRAIN)) begin
                r_wd_cnt <= r_wd_cnt + WD_W'(1);
            end else begin
                r_wd_cnt <= '0;
            end

            if (flush) begin
                r_block_cnt <= '0;
            end else if (w_drain_done) begin
                r_block_cnt <= r_block_cnt + BLK_IDX_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : output_regs
        if (!rst_n) begin
            r_m_valid     <= 1'b0;
            r_m_first     <= 1'b0;
            r_m_last      <= 1'b0;
            r_m_data      <= '0;
            r_m_block_idx <= '0;
        end else begin
            r_m_valid <= w_beat;
            r_m_first <= w_beat && (r_out_cnt == '0);
            r_m_last  <= w_beat && is_last(r_out_cnt);
            if (w_beat) begin
                r_m_data      <= dp_out_sample;
                r_m_block_idx <= r_block_cnt;
            end
        end
    end

    // Sticky errors: a new set event outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin : error_regs
        if (!rst_n) begin
            r_err_timeout    <= 1'b0;
            r_err_unexpected <= 1'b0;
        end else begin
            if (w_wd_expire) begin
                r_err_timeout <= 1'b1;
            end else if (err_clear) begin
                r_err_timeout <= 1'b0;
            end

            if (w_unexpected) begin
                r_err_unexpected <= 1'b1;
            end else if (err_clear) begin
                r_err_unexpected <= 1'b0;
            end
        end
    end

    assign s_ready        = w_s_ready;
    assign dp_in_valid    = w_dp_in_valid;
    assign dp_in_sample   = w_dp_in_sample;
    assign dp_rst_n       = r_dp_rst_n;
    assign busy           = w_busy;
    assign m_valid        = r_m_valid;
    assign m_first        = r_m_first;
    assign m_last         = r_m_last;
    assign m_data         = r_m_data;
    assign m_block_idx    = r_m_block_idx;
    assign err_timeout    = r_err_timeout;
    assign err_unexpected = r_err_unexpected;

endmodule

// File: doc/dct8_block_sequencer.md
Name: dct8_block_sequencer

Overview:
- Block-level controller in front of the dct8_stage1 datapath.
- dct8_stage1 has no input backpressure and silently ignores in_valid while computing or outputting. This block provides a ready/valid upstream interface and admits exactly 8 samples per block.
- It holds the upstream off until all 8 butterfly outputs have returned, then frames those outputs with first/last/block index.
- It also resets the datapath on power-up, on explicit flush and on watchdog timeout.

Parameters:
- DATA_IN_WIDTH, 12, upstream/datapath input sample width
- DATA_OUT_WIDTH, 16, datapath/downstream output sample width
- TIMEOUT_CYCLES, 32, maximum DRAIN cycles before a watchdog error
- FLUSH_CYCLES, 2, cycles dp_rst_n is held low per flush (minimum 1)
- BLK_IDX_WIDTH, 8, width of the block counter (wraps)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  upstream sample valid
- s_ready  out  1  upstream ready (combinational from state)
- s_data  in  DATA_IN_WIDTH  upstream sample, signed
- dp_in_valid  out  1  to dct8_stage1 in_valid
- dp_in_sample  out  DATA_IN_WIDTH  to dct8_stage1 in_sample
- dp_rst_n  out  1  to dct8_stage1 rst_n (registered)
- dp_out_valid  in  1  from dct8_stage1 out_valid
- dp_out_sample  in  DATA_OUT_WIDTH  from dct8_stage1 out_sample
- m_valid  out  1  downstream valid (no backpressure)
- m_data  out  DATA_OUT_WIDTH  butterfly output y(k)
- m_first  out  1  high with y(0)
- m_last  out  1  high with y(7)
- m_block_idx  out  BLK_IDX_WIDTH  index of the emitted block
- flush  in  1  synchronous abort request
- err_clear  in  1  clears sticky errors
- busy  out  1  state != FEED or feed_cnt != 0
- err_timeout  out  1  sticky watchdog error
- err_unexpected  out  1  sticky: dp_out_valid seen outside DRAIN

Behaviour:
- Reset (async):
  - state=FLUSH, dp_rst_n=0.
  - All counters 0; m_valid, m_first, m_last, m_data, m_block_idx = 0.
  - Both errors 0.
- States: FLUSH, FEED, DRAIN.
- FLUSH:
  - dp_rst_n=0 and s_ready=0; flush_cnt counts FLUSH_CYCLES.
  - On the last count: dp_rst_n<=1, feed_cnt=out_cnt=0, go to FEED.
- FEED:
  - s_ready = !flush.
  - dp_in_valid = s_valid & s_ready, dp_in_sample = s_data. Both are combinational pass-throughs and are forced 0 outside FEED.
  - Each handshake increments feed_cnt (0..7). The 8th handshake goes to DRAIN with out_cnt=0 and wd_cnt=0.
  - Bubbles on s_valid are allowed; the count is kept.
- DRAIN:
  - s_ready=0; wd_cnt increments each cycle.
  - Each cycle with dp_out_valid:
    - m_valid<=1, m_data<=dp_out_sample.
    - m_first<=(out_cnt==0), m_last<=(out_cnt==7), m_block_idx<=block_cnt.
    - out_cnt increments.
  - The 8th beat goes to FEED with block_cnt+1 (wrap).
  - If wd_cnt reaches TIMEOUT_CYCLES before the 8th beat: err_timeout<=1, go to FLUSH. Partial outputs already emitted stand; m_last is never sent for that block.
- m_valid, m_first and m_last default to 0 every cycle (single-cycle pulses).
- Unexpected output: dp_out_valid in FEED or FLUSH sets err_unexpected, and the beat is dropped (no m_valid).
- Flush input: if sampled high in any state, next state is FLUSH and the partial block is discarded. Flush beats timeout and normal transitions; block_cnt is cleared to 0. Flush held high keeps the block in FLUSH.
- Errors: err_clear clears both errors. A set event in the same cycle as err_clear wins.
- Latency with dct8_stage1 attached, first sample accepted at edge E0 and 8 consecutive handshakes E0..E7:
  - dp_out_valid sampled at E10..E17.
  - m_valid high after E10..E17.
  - s_ready re-asserts after E17.
  - Block period 18 cycles.
- Arithmetic: none; widths pass through unchanged.

Decomposition:
- dct8_pkg holds N=8, the state encoding localparams (FLUSH/FEED/DRAIN), and default widths shared with dct8_stage1.
- No sub-module: the counters and FSM stay in one module. The top level instantiates dct8_block_sequencer beside dct8_stage1.

Test Plan:
- Reset release -> dp_rst_n low exactly 2 edges after rst_n rises, s_ready=0 meanwhile, then s_ready=1, busy=0.
- Single block s_data=1..8 with the real stage -> m_data 9,9,9,9,-1,-3,-5,-7; m_first on the first beat, m_last on -7; m_block_idx=0; m_valid first after E10.
- s_valid held high for 3 blocks -> s_ready low 10 cycles per block, period 18, m_block_idx 0,1,2, no err flags.
- Random s_valid gaps (50%) -> dp_in_valid never high outside FEED; outputs equal the per-block butterfly of accepted samples.
- Stub datapath never returns out_valid -> err_timeout=1 after 32 DRAIN cycles, dp_rst_n low 2 cycles, s_ready returns; err_clear -> err_timeout=0.
- Flush after 3 accepted samples, then 8 samples 1..8 -> clean block 9,9,9,9,-1,-3,-5,-7 with idx 0. Forced dp_out_valid during FEED -> err_unexpected=1, no m_valid.
